// File: rtl/rtc_seq_pkg.sv
// rtc_seq_pkg: shared state type, mode table and timeout constant for the RTC command sequencer.
// RTC_SEQ_TIMEOUT only takes effect in builds with RTC_SEQ_TIMEOUT_EN defined.
package rtc_seq_pkg;
   typedef enum logic [2:0] {S_IDLE, S_CMD, S_DATA, S_DONE, S_ERR} seq_state_e;
   localparam int MODE_NUM = 4;
   localparam logic [7:0] MODE_CMD  [MODE_NUM] = '{8'hF0, 8'hF1, 8'hF1, 8'h08};
   localparam logic [7:0] MODE_BASE [MODE_NUM] = '{8'h21, 8'h24, 8'h21, 8'h41};
   localparam int         MODE_CNT  [MODE_NUM] = '{6, 3, 6, 3};
   localparam logic [7:0] UNUSED_CMD = 8'h0F;
   localparam int RTC_SEQ_TIMEOUT = 255;
   typedef struct packed {
      logic [7:0] cmd;
      logic [7:0] base;
      int         cnt;
   } mode_entry_t;
   function automatic mode_entry_t mode_lookup(input int unsigned m);
      mode_entry_t e;
      e = '{cmd: UNUSED_CMD, base: 8'h00, cnt: 0};
      if (m < MODE_NUM) e = '{cmd: MODE_CMD[m[1:0]], base: MODE_BASE[m[1:0]], cnt: MODE_CNT[m[1:0]]};
      return e;
   endfunction
endpackage

// File: rtl/rtc_cmd_sequencer_if.sv
// rtc_cmd_sequencer_if: single-access RTC bus between the sequencer (master) and the bus driver (slave).
interface rtc_cmd_sequencer_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);
   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic              bus_ack;
   logic [DATA_W-1:0] bus_rdata;
   modport master (output bus_req, bus_we, bus_addr, bus_wdata, input bus_ack, bus_rdata);
   modport slave (input bus_req, bus_we, bus_addr, bus_wdata, output bus_ack, bus_rdata);
endinterface

// File: rtl/rtc_mode_table.sv
// rtc_mode_table: combinational mode -> {command, base address, byte count} lookup.
// Counts above MAX_BYTES are clamped so the burst never overruns the byte index.
module rtc_mode_table import rtc_seq_pkg::*; #(
   parameter int ADDR_W    = 8,
   parameter int MODE_W    = 2,
   parameter int MAX_BYTES = 8,
   parameter int CNT_W     = 4
) (
   input  logic [MODE_W-1:0] mode_i,
   output logic [ADDR_W-1:0] cmd_o,
   output logic [ADDR_W-1:0] base_o,
   output logic [CNT_W-1:0]  cnt_o
);
   mode_entry_t e;
   always_comb begin
      e      = mode_lookup(32'(mode_i));
      cmd_o  = ADDR_W'(e.cmd);
      base_o = ADDR_W'(e.base);
      cnt_o  = (e.cnt > MAX_BYTES) ? CNT_W'(MAX_BYTES) : CNT_W'(e.cnt);
   end
endmodule

// File: rtl/rtc_cmd_sequencer.sv
// rtc_cmd_sequencer: issues the RTC command byte, then bursts the mode's register accesses.
// Define RTC_SEQ_TIMEOUT_EN to abort an access whose bus_ack never arrives.
module rtc_cmd_sequencer import rtc_seq_pkg::*; #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 8,
   parameter int MODE_W    = 2,
   parameter int MAX_BYTES = 8,
   localparam int IDX_W    = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1,
   localparam int CNT_W    = $clog2(MAX_BYTES + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [MODE_W-1:0]   mode,
   input  logic                dir_rd,
   input  logic [DATA_W-1:0]   wr_data,
   rtc_cmd_sequencer_if.master bus,
   output logic [IDX_W-1:0]    byte_idx,
   output logic                wr_take,
   output logic                rd_valid,
   output logic [DATA_W-1:0]   rd_data,
   output logic                busy,
   output logic                done,
   output logic                err
);
   seq_state_e        state_q, state_d;
   logic              req_q, req_d, we_q, we_d, dir_q, dir_d, rd_valid_q, rd_valid_d;
   logic [ADDR_W-1:0] addr_q, addr_d, base_q, base_d, tbl_cmd, tbl_base;
   logic [DATA_W-1:0] wdata_q, wdata_d, rd_data_q, rd_data_d;
   logic [IDX_W-1:0]  idx_q, idx_d, rd_idx_q, rd_idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, tbl_cnt;
   logic              last, expired;

   rtc_mode_table #(.ADDR_W(ADDR_W), .MODE_W(MODE_W), .MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W)) u_table (
      .mode_i(mode), .cmd_o(tbl_cmd), .base_o(tbl_base), .cnt_o(tbl_cnt)
   );

   assign last = (CNT_W'(idx_q) + CNT_W'(1)) == cnt_q;

`ifdef RTC_SEQ_TIMEOUT_EN
   localparam int TMO_W = $clog2(RTC_SEQ_TIMEOUT + 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
   assign tmo_d   = req_q ? tmo_q + TMO_W'(1) : '0;
   assign expired = req_q && !bus.bus_ack && tmo_q == TMO_W'(RTC_SEQ_TIMEOUT - 1);
   assign err     = state_q == S_ERR;
   always_ff @(posedge clk) tmo_q <= reset ? '0 : tmo_d;
`else
   assign expired = 1'b0;
   assign err     = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      base_d     = base_q;
      cnt_d      = cnt_q;
      dir_d      = dir_q;
      idx_d      = idx_q;
      rd_idx_d   = rd_idx_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      wr_take    = 1'b0;
      case (state_q)
         S_IDLE: if (start) begin
            state_d = S_CMD;
            req_d   = 1'b1;
            we_d    = 1'b1;
            addr_d  = tbl_cmd;
            wdata_d = DATA_W'(tbl_cmd);
            base_d  = tbl_base;
            cnt_d   = tbl_cnt;
            dir_d   = dir_rd;
            idx_d   = '0;
         end
         S_CMD: if (bus.bus_ack) begin
            req_d   = 1'b0;
            state_d = (cnt_q == '0) ? S_DONE : S_DATA;
         end
         // With bus_req low, DATA is the setup cycle: latch address and write byte, then request.
         S_DATA: if (!req_q) begin
            req_d   = 1'b1;
            we_d    = !dir_q;
            addr_d  = base_q + ADDR_W'(idx_q);
            wr_take = !dir_q;
            wdata_d = dir_q ? wdata_q : wr_data;
         end else if (bus.bus_ack) begin
            req_d      = 1'b0;
            rd_valid_d = dir_q;
            rd_idx_d   = idx_q;
            rd_data_d  = dir_q ? bus.bus_rdata : rd_data_q;
            state_d    = last ? S_DONE : S_DATA;
            idx_d      = last ? idx_q : idx_q + IDX_W'(1);
         end
         default: state_d = S_IDLE;
      endcase
      if (expired) begin
         state_d = S_ERR;
         req_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         base_q     <= '0;
         cnt_q      <= '0;
         dir_q      <= 1'b0;
         idx_q      <= '0;
         rd_idx_q   <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         base_q     <= base_d;
         cnt_q      <= cnt_d;
         dir_q      <= dir_d;
         idx_q      <= idx_d;
         rd_idx_q   <= rd_idx_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // A read's rd_valid cycle reports the index of the byte just read, not the next one.
   assign byte_idx      = rd_valid_q ? rd_idx_q : idx_q;
   assign bus.bus_req   = req_q;
   assign bus.bus_we    = we_q;
   assign bus.bus_addr  = addr_q;
   assign bus.bus_wdata = wdata_q;
   assign rd_valid      = rd_valid_q;
   assign rd_data       = rd_data_q;
   assign busy          = state_q != S_IDLE;
   assign done          = state_q == S_DONE;
endmodule

// File: tb/tb_rtc_cmd_sequencer.sv
// tb_rtc_cmd_sequencer: directed and randomized transfers checked against a transfer-level model.
// Exercises the timeout path only when RTC_SEQ_TIMEOUT_EN is defined.
module tb_rtc_cmd_sequencer;
   logic       clk = 1'b0;
   logic       reset, start, dir_rd;
   logic [2:0] mode;
   logic [7:0] wr_data, rd_data;
   logic [2:0] byte_idx;
   logic       wr_take, rd_valid, busy, done, err;
   int         checks = 0, passed = 0, fails = 0;
   logic [7:0] wtab [8];
   logic [7:0] rtab [8];

   rtc_cmd_sequencer_if #(.DATA_W(8), .ADDR_W(8)) bus_if ();

   rtc_cmd_sequencer #(.DATA_W(8), .ADDR_W(8), .MODE_W(3), .MAX_BYTES(8)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .dir_rd(dir_rd), .wr_data(wr_data),
      .bus(bus_if), .byte_idx(byte_idx), .wr_take(wr_take), .rd_valid(rd_valid), .rd_data(rd_data),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   function automatic void ref_entry(input int m, output logic [7:0] cmd, output logic [7:0] base, output int cnt);
      case (m)
         0:       begin cmd = 8'hF0; base = 8'h21; cnt = 6; end
         1:       begin cmd = 8'hF1; base = 8'h24; cnt = 3; end
         2:       begin cmd = 8'hF1; base = 8'h21; cnt = 6; end
         3:       begin cmd = 8'h08; base = 8'h41; cnt = 3; end
         default: begin cmd = 8'h0F; base = 8'h00; cnt = 0; end
      endcase
      if (cnt > 8) cnt = 8;
   endfunction

   // k counts acks given: access 0 is the command byte, access k>0 is data byte k-1.
   task automatic run_xfer(input int m, input bit rd, input int dmin, input int dmax, input int abort_k);
      logic [7:0] cmd, base, ea;
      int cnt, k, wait_c;
      bit prev_ack, fin, e_take, e_rdv, e_done, e_req;
      ref_entry(m, cmd, base, cnt);
      @(negedge clk);
      start = 1'b1; mode = 3'(m); dir_rd = rd;
      k = 0; wait_c = -1; prev_ack = 0; fin = 0;
      for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
         @(negedge clk);
         bus_if.bus_ack = 1'b0;
         e_done = prev_ack && k == cnt + 1;
         e_rdv  = prev_ack && rd && k >= 2;
         e_take = prev_ack && !rd && k >= 1 && k <= cnt;
         e_req  = !prev_ack && k <= cnt;
         start  = e_done ? 1'b1 : 1'($urandom);
         mode   = 3'($urandom);
         dir_rd = 1'($urandom);
         chk("busy", busy, 1);
         chk("done", done, e_done);
         chk("rd_valid", rd_valid, e_rdv);
         chk("wr_take", wr_take, e_take);
         chk("bus_req", bus_if.bus_req, e_req);
         chk("err", err, 0);
         if (e_rdv) begin
            chk($sformatf("rd_data%0d", k - 2), rd_data, rtab[k-2]);
            chk($sformatf("rd_idx%0d", k - 2), byte_idx, k - 2);
         end
         if (e_take) chk($sformatf("wr_idx%0d", k - 1), byte_idx, k - 1);
         wr_data  = e_take ? wtab[k-1] : 8'($urandom);
         prev_ack = 0;
         if (e_done) fin = 1;
         else if (e_req && abort_k == k && wait_c < 0) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0; start = 1'b0;
            chk("rst_req", bus_if.bus_req, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            repeat (4) begin
               @(negedge clk);
               chk("rst_no_done", done, 0);
               chk("rst_idle", busy, 0);
            end
            return;
         end else if (e_req) begin
            ea = 8'(int'(base) + k - 1);
            if (wait_c < 0) begin
               chk($sformatf("we%0d", k), bus_if.bus_we, k == 0 ? 1 : !rd);
               chk($sformatf("addr%0d", k), bus_if.bus_addr, k == 0 ? cmd : ea);
               if (k == 0) chk("cmd_wdata", bus_if.bus_wdata, cmd);
               wait_c = $urandom_range(dmax, dmin);
            end
            if (wait_c == 0) begin
               if (k > 0 && !rd) chk($sformatf("wdata%0d", k - 1), bus_if.bus_wdata, wtab[k-1]);
               bus_if.bus_ack   = 1'b1;
               bus_if.bus_rdata = (k > 0 && rd) ? rtab[k-1] : 8'($urandom);
               k++; prev_ack = 1; wait_c = -1;
            end else wait_c--;
         end
      end
      if (!fin) chk("xfer_timeout", 0, 1);
      @(negedge clk);
      start = 1'b0;
      bus_if.bus_ack = 1'b1;
      chk("post_busy", busy, 0);
      chk("post_req", bus_if.bus_req, 0);
      chk("post_done", done, 0);
      @(negedge clk);
      bus_if.bus_ack = 1'b0;
      chk("stray_ack_busy", busy, 0);
      chk("stray_ack_req", bus_if.bus_req, 0);
   endtask

   initial begin
      int n;
      reset = 1'b1; start = 1'b0; mode = '0; dir_rd = 1'b0; wr_data = '0;
      bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_req", bus_if.bus_req, 0);
      chk("rst_we", bus_if.bus_we, 0);
      chk("rst_addr", bus_if.bus_addr, 0);
      chk("rst_wdata", bus_if.bus_wdata, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_wr_take", wr_take, 0);
      chk("rst_idx", byte_idx, 0);
      reset = 1'b0;
      wtab[0] = 8'h15; wtab[1] = 8'h04; wtab[2] = 8'h16;
      run_xfer(1, 0, 2, 2, -1);
      for (int i = 0; i < 8; i++) rtab[i] = 8'(i);
      run_xfer(0, 1, 0, 2, -1);
      for (int i = 0; i < 8; i++) wtab[i] = 8'($urandom);
      run_xfer(2, 0, 0, 1, 3);
      run_xfer(2, 0, 0, 1, -1);
      run_xfer(5, 0, 0, 2, -1);
      run_xfer(3, 1, 1, 3, -1);
      for (int t = 0; t < 24; t++) begin
         for (int i = 0; i < 8; i++) begin
            wtab[i] = 8'($urandom);
            rtab[i] = 8'($urandom);
         end
         run_xfer($urandom_range(7, 0), 1'($urandom), 0, 3, -1);
      end
`ifdef RTC_SEQ_TIMEOUT_EN
      @(negedge clk);
      start = 1'b1; mode = 3'd3; dir_rd = 1'b0;
      @(negedge clk);
      start = 1'b0; n = 0;
      while (bus_if.bus_req && n < 1000) begin
         n++;
         @(negedge clk);
      end
      chk("tmo_len", n, 255);
      chk("tmo_err", err, 1);
      chk("tmo_req", bus_if.bus_req, 0);
      chk("tmo_done", done, 0);
      @(negedge clk);
      chk("tmo_err_pulse", err, 0);
      chk("tmo_busy", busy, 0);
`else
      n = 0;
      chk("no_tmo_err", err, 0);
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/rtc_cmd_sequencer.md
# rtc_cmd_sequencer

Parametrised command/transfer sequencer for the RTC bus. Given a transfer mode and direction, it issues the RTC command byte, then bursts N register accesses (read or write) through the single-access RTC bus driver. It also reports byte-indexed data to or from the clock/date/timer register bank, and signals completion. It sits between the clock controller FSM and the RTC bus driver, and replaces the fixed combinational command lookup.

## Interface
- `DATA_W`, 8, data width of RTC registers and bus.
- `ADDR_W`, 8, RTC address/command width.
- `MODE_W`, 2, mode select width; number of modes is 2**MODE_W.
- `MAX_BYTES`, 8, maximum data bytes per transfer; sets the width of `byte_idx`, which is clog2(MAX_BYTES).
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `mode`  in  MODE_W  transfer mode; captured with `start`.
- `dir_rd`  in  1  1 = read RTC, 0 = write RTC; captured with `start`.
- `wr_data`  in  DATA_W  write byte for index `byte_idx`; sampled when `wr_take`=1.
- `bus_ack`  in  1  one-cycle completion from bus driver; `bus_rdata` is valid with it.
- `bus_rdata`  in  DATA_W  read data from bus driver.
- `bus_req`  out  1  access request; held until `bus_ack`.
- `bus_we`  out  1  access is a write.
- `bus_addr`  out  ADDR_W  command byte or register address.
- `bus_wdata`  out  DATA_W  write data.
- `byte_idx`  out  clog2(MAX_BYTES)  current data byte index.
- `wr_take`  out  1  pulse; `wr_data` consumed this cycle.
- `rd_valid`  out  1  pulse; `rd_data` is valid for `byte_idx`.
- `rd_data`  out  DATA_W  captured read byte.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle abort pulse (timeout build only; otherwise tied to 0).

## Operation
- Mode table, indexed by `mode`, gives cmd / base / count:
  - 0: F0 / 0x21 / 6 (clock + timer)
  - 1: F1 / 0x24 / 3 (date)
  - 2: F1 / 0x21 / 6 (date + clock)
  - 3: 08 / 0x41 / 3 (timer)
  - Unused entries: 0F / 0x00 / 0.
  - A count above MAX_BYTES is clamped to MAX_BYTES.
- FSM states:
  - IDLE –`start`→ CMD.
  - CMD –`bus_ack`→ DATA, or DONE if count=0.
  - DATA –`bus_ack` on last byte→ DONE, otherwise DATA with `byte_idx`+1.
  - DONE → IDLE after one cycle.
  - ERR → IDLE after one cycle (timeout build only).
- CMD phase: `bus_we`=1, `bus_addr`=cmd, `bus_wdata`=cmd.
- DATA phase: `bus_addr`=base+`byte_idx`, computed modulo 2**ADDR_W (wraps). `bus_we`=!`dir_rd`.
- Write byte: `wr_take` pulses on the first cycle of each DATA access. `wr_data` is registered into `bus_wdata` and held stable until `bus_ack`.
- Read byte: on `bus_ack`, `rd_data`<=`bus_rdata` and `rd_valid` pulses the next cycle with the matching `byte_idx`.
- `start` while busy is ignored; no queueing. `mode` and `dir_rd` changes mid-transfer have no effect.
- `bus_ack` outside CMD/DATA is ignored.

## Timing
- Reset values: state IDLE; all outputs 0; `bus_addr`, `bus_wdata` and `rd_data` are 0x00.
- `start` at cycle t → `busy` and `bus_req` high at t+1.
- Each access takes one cycle from `bus_ack` to the next `bus_req`. `bus_req` drops for exactly one cycle between accesses.
- Last `bus_ack` at cycle a → `done` at a+1 and `busy` low at a+2.
- `reset` mid-transfer: return to IDLE next cycle, `bus_req` deasserted, no `done`.
- `start` in the same cycle as `done` is ignored.

## Configuration
- `RTC_SEQ_TIMEOUT_EN` defined:
  - A counter of `RTC_SEQ_TIMEOUT` cycles (package constant, default 255) restarts on every `bus_req` rise.
  - On expiry without `bus_ack`: go to ERR, pulse `err`, drop `bus_req`, no `done`.
- Undefined: waits indefinitely for `bus_ack`; `err` is tied to 0.

## Structure
- Package `rtc_seq_pkg`: state enum; mode table constants (cmd/base/count arrays); `RTC_SEQ_TIMEOUT`.
- Sub-module `rtc_mode_table`: combinational mode → {cmd, base, count} lookup, successor of the legacy command decoder.

## Test plan
- Write mode 1: start, then ack each access after 2 cycles → bus sees F1 (we=1), then 0x24/0x25/0x26 with wr_data 0x15/0x04/0x16; 3 `wr_take` pulses; `done` 1 cycle after the 4th ack.
- Read mode 0: 6 acks returning 0x00..0x05 → `rd_valid` ×6, with `rd_data`=0x00..0x05 at `byte_idx` 0..5.
- `start` asserted while busy, and again in the `done` cycle → ignored; exactly one command byte issued.
- `reset` during DATA byte 2 of mode 2 → IDLE next cycle; `bus_req`=0; no `done`; a fresh start then works normally.
- Unused mode (MODE_W=3, mode 5) → command 0F only, then `done` with no data accesses.
- With `RTC_SEQ_TIMEOUT_EN`, withhold `bus_ack` → `err` pulses after 255 cycles; `bus_req` drops; `busy` clears.
